// File: rtl/leaf_arb_pkg.sv
// Shared types and helpers for the leaf output round-robin arbiter and its
// input-side counterparts.
package leaf_arb_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } arb_state_e;

    // Upper bound on requesters handled by the rotated-priority pick.
    localparam int unsigned MaxReq     = 32;
    localparam int unsigned MaxReqBits = 5;

    function automatic int unsigned req_bits(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int unsigned burst_bits(input int unsigned max_burst);
        return $clog2(max_burst) + 1;
    endfunction

    // First set bit scanning ptr, ptr+1, ... with explicit wrap at num_req; -1 if none.
    function automatic int rr_pick_idx(input logic [MaxReq-1:0] vld,
                                       input int unsigned num_req,
                                       input int unsigned ptr);
        int          result;
        int unsigned cand;
        result = -1;
        for (int unsigned k = 0; k < MaxReq; k++) begin
            cand = ptr + k;
            if (cand >= num_req) begin
                cand = cand - num_req;
            end
            if ((k < num_req) && (result < 0) && vld[cand[MaxReqBits-1:0]]) begin
                result = int'(cand);
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/leaf_out_rr_arbiter_rr_pick.sv
// Combinational rotated-priority picker: returns the first valid requester
// at or after the round-robin pointer.
module leaf_out_rr_arbiter_rr_pick
    import leaf_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ  = 2,
    parameter int unsigned REQ_BITS = req_bits(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  i_vld,
    input  logic [REQ_BITS-1:0] i_ptr,
    output logic                o_found,
    output logic [REQ_BITS-1:0] o_idx
);

    logic [MaxReq-1:0] w_vld_ext;
    int                w_pick;

    always_comb begin
        w_vld_ext              = '0;
        w_vld_ext[NUM_REQ-1:0] = i_vld;
        w_pick                 = rr_pick_idx(w_vld_ext, NUM_REQ, 32'(i_ptr));
        o_found                = (w_pick >= 0);
        o_idx                  = o_found ? REQ_BITS'(w_pick) : '0;
    end

endmodule

// File: rtl/leaf_out_rr_arbiter.sv
// Round-robin arbiter sharing one leaf user-to-interface port between several
// operator output streams, with bounded bursts and a registered output stage.
module leaf_out_rr_arbiter
    import leaf_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned PAYLOAD_BITS = 32,
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned REQ_BITS     = req_bits(NUM_REQ),
    parameter int unsigned BURST_BITS   = burst_bits(MAX_BURST)
) (
    input  logic                            i_clk,
    input  logic                            i_reset,
    input  logic                            i_enable,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] i_din_req,
    input  logic [NUM_REQ-1:0]              i_vld_req,
    output logic [NUM_REQ-1:0]              o_ack_req,
    output logic [PAYLOAD_BITS-1:0]         o_dout,
    output logic                            o_vld_out,
    input  logic                            i_ack_in,
    output logic [REQ_BITS-1:0]             o_src_out,
    output logic                            o_busy
);

    arb_state_e              r_state, w_state_nxt;
    logic [REQ_BITS-1:0]     r_rr_ptr, w_rr_ptr_nxt;
    logic [REQ_BITS-1:0]     r_grant_idx, w_grant_idx_nxt;
    logic [BURST_BITS-1:0]   r_burst_cnt, w_burst_cnt_nxt;
    logic                    r_vld_out;
    logic [PAYLOAD_BITS-1:0] r_dout;
    logic [REQ_BITS-1:0]     r_src_out;

    logic                    w_pick_found;
    logic [REQ_BITS-1:0]     w_pick_idx;
    logic [REQ_BITS-1:0]     w_ptr_after;
    logic [PAYLOAD_BITS-1:0] w_din_sel;
    logic                    w_grant_vld;
    logic                    w_in_grant;
    logic                    w_free;
    logic                    w_xfer;
    logic                    w_burst_last;
    logic                    w_release;

    leaf_out_rr_arbiter_rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .REQ_BITS (REQ_BITS)
    ) u_rr_pick (
        .i_vld   (i_vld_req),
        .i_ptr   (r_rr_ptr),
        .o_found (w_pick_found),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_din_sel   = '0;
        w_grant_vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_idx == REQ_BITS'(i)) begin
                w_din_sel   = i_din_req[i*PAYLOAD_BITS +: PAYLOAD_BITS];
                w_grant_vld = i_vld_req[i];
            end
        end
    end

    assign w_in_grant   = (r_state == StGrant);
    assign w_free       = !r_vld_out || i_ack_in;
    assign w_xfer       = w_in_grant && w_grant_vld && w_free;
    assign w_burst_last = (r_burst_cnt == BURST_BITS'(MAX_BURST - 1));
    assign w_release    = (w_xfer && w_burst_last) || !w_grant_vld || !i_enable;
    // Explicit wrap so non-power-of-two requester counts rotate correctly.
    assign w_ptr_after  = (r_grant_idx == REQ_BITS'(NUM_REQ - 1)) ? '0
                                                                   : r_grant_idx + REQ_BITS'(1);

    // Gated by reset so no requester sees a handshake during the reset cycle.
    always_comb begin
        o_ack_req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            o_ack_req[i] = w_in_grant && w_free && !i_reset && (r_grant_idx == REQ_BITS'(i));
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_grant_idx_nxt = r_grant_idx;
        w_burst_cnt_nxt = r_burst_cnt;
        unique case (r_state)
            StIdle: begin
                if (i_enable && w_pick_found) begin
                    w_state_nxt     = StGrant;
                    w_grant_idx_nxt = w_pick_idx;
                    w_burst_cnt_nxt = '0;
                end
            end
            StGrant: begin
                if (w_release) begin
                    w_state_nxt  = StIdle;
                    w_rr_ptr_nxt = w_ptr_after;
                end else if (w_xfer) begin
                    w_burst_cnt_nxt = r_burst_cnt + BURST_BITS'(1);
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_rr_ptr    <= '0;
            r_grant_idx <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_grant_idx <= w_grant_idx_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_vld_out <= 1'b0;
            r_dout    <= '0;
            r_src_out <= '0;
        end else if (w_xfer) begin
            r_vld_out <= 1'b1;
            r_dout    <= w_din_sel;
            r_src_out <= r_grant_idx;
        end else if (w_free) begin
            r_vld_out <= 1'b0;
        end
    end

    assign o_vld_out = r_vld_out;
    assign o_dout    = r_dout;
    assign o_src_out = r_src_out;
    assign o_busy    = w_in_grant || r_vld_out;

endmodule

// File: tb/tb_leaf_out_rr_arbiter.sv
// Scoreboard bench for leaf_out_rr_arbiter: a grant-level reference model
// predicts acks and output words; a monitor checks words as they are taken.
module tb_leaf_out_rr_arbiter;

    localparam int NUM_REQ      = 3;
    localparam int PAYLOAD_BITS = 32;
    localparam int MAX_BURST    = 4;
    localparam int REQ_BITS     = 2;
    localparam int TOTAL_CYC    = 900;
    localparam int DRAIN_CYC    = 15;

    typedef struct {
        int                      src;
        logic [PAYLOAD_BITS-1:0] data;
    } exp_t;

    logic                            clk = 1'b0;
    logic                            i_reset;
    logic                            i_enable;
    logic [NUM_REQ*PAYLOAD_BITS-1:0] i_din_req;
    logic [NUM_REQ-1:0]              i_vld_req;
    logic [NUM_REQ-1:0]              o_ack_req;
    logic [PAYLOAD_BITS-1:0]         o_dout;
    logic                            o_vld_out;
    logic                            i_ack_in;
    logic [REQ_BITS-1:0]             o_src_out;
    logic                            o_busy;

    always #5 clk = ~clk;

    leaf_out_rr_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .PAYLOAD_BITS (PAYLOAD_BITS),
        .MAX_BURST    (MAX_BURST)
    ) dut (
        .i_clk     (clk),
        .i_reset   (i_reset),
        .i_enable  (i_enable),
        .i_din_req (i_din_req),
        .i_vld_req (i_vld_req),
        .o_ack_req (o_ack_req),
        .o_dout    (o_dout),
        .o_vld_out (o_vld_out),
        .i_ack_in  (i_ack_in),
        .o_src_out (o_src_out),
        .o_busy    (o_busy)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    bit   started  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Driver plus reference model: owner = requester holding the grant (-1 while arbitrating).
    initial begin
        int                 seq[NUM_REQ];
        logic [NUM_REQ-1:0] hs;
        logic [NUM_REQ-1:0] gate;
        logic [NUM_REQ-1:0] exp_ack;
        bit                 rst, en, ack, free, xfer, was_reset;
        int                 m_owner, m_ptr, m_count;
        bit                 m_vld;

        i_reset   = 1'b1;
        i_enable  = 1'b0;
        i_ack_in  = 1'b0;
        i_vld_req = '0;
        i_din_req = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_vld_out", 64'(o_vld_out), 64'(0));
        check("reset_dout", 64'(o_dout), 64'(0));
        check("reset_src_out", 64'(o_src_out), 64'(0));
        check("reset_busy", 64'(o_busy), 64'(0));
        check("reset_ack_req", 64'(o_ack_req), 64'(0));

        for (int i = 0; i < NUM_REQ; i++) seq[i] = 0;
        hs        = '0;
        m_owner   = -1;
        m_ptr     = 0;
        m_count   = 0;
        m_vld     = 1'b0;
        was_reset = 1'b1;
        started   = 1'b1;

        for (int cyc = 0; cyc < TOTAL_CYC + DRAIN_CYC; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < NUM_REQ; i++) if (hs[i]) seq[i]++;
            if (was_reset) begin
                check("post_reset_dout", 64'(o_dout), 64'(0));
                check("post_reset_src_out", 64'(o_src_out), 64'(0));
            end

            rst = 1'b0;
            if (cyc < 150) begin
                en   = 1'b1;
                ack  = !(cyc >= 60 && cyc < 65);
                gate = '1;
            end else if (cyc < 600) begin
                en  = ($urandom % 10) != 0;
                ack = ($urandom % 10) < 7;
                for (int i = 0; i < NUM_REQ; i++) gate[i] = ($urandom % 10) < 7;
                rst = (cyc == 350) || (cyc == 351);
            end else if (cyc < TOTAL_CYC) begin
                en  = ($urandom % 30) != 0;
                ack = ($urandom % 10) < 3;
                for (int i = 0; i < NUM_REQ; i++) gate[i] = ($urandom % 10) < 9;
            end else begin
                en   = 1'b1;
                ack  = 1'b1;
                gate = '0;
            end
            if (rst) ack = 1'b0;

            i_reset   = rst;
            i_enable  = en;
            i_ack_in  = ack;
            i_vld_req = gate;
            for (int i = 0; i < NUM_REQ; i++) begin
                i_din_req[i*PAYLOAD_BITS +: PAYLOAD_BITS] = {8'(i), 24'(seq[i])};
            end
            #1;

            exp_ack = '0;
            check("vld_out", 64'(o_vld_out), 64'(m_vld));
            if (rst) begin
                check("ack_req_in_reset", 64'(o_ack_req), 64'(0));
                exp_q.delete();
                m_owner = -1;
                m_ptr   = 0;
                m_vld   = 1'b0;
            end else begin
                check("busy", 64'(o_busy), 64'((m_owner >= 0) || m_vld));
                free = !m_vld || ack;
                xfer = 1'b0;
                if (m_owner < 0) begin
                    if (en && (gate != '0)) begin
                        m_owner = pick(gate, m_ptr);
                        m_count = 0;
                    end
                end else begin
                    if (free) exp_ack[m_owner] = 1'b1;
                    xfer = gate[m_owner] && free;
                    if (xfer) begin
                        exp_q.push_back('{m_owner, i_din_req[m_owner*PAYLOAD_BITS +: PAYLOAD_BITS]});
                        m_count++;
                    end
                    if ((xfer && m_count == MAX_BURST) || !gate[m_owner] || !en) begin
                        m_ptr   = (m_owner + 1) % NUM_REQ;
                        m_owner = -1;
                    end
                end
                check("ack_req", 64'(o_ack_req), 64'(exp_ack));
                m_vld = xfer ? 1'b1 : (free ? 1'b0 : m_vld);
            end
            hs        = i_vld_req & o_ack_req;
            was_reset = rst;
        end

        @(negedge clk);
        #3;
        check("drain_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Monitor: compares each taken word with the scoreboard and checks hold stability.
    initial begin
        exp_t                    e;
        bit                      hold_prev;
        logic [PAYLOAD_BITS-1:0] hold_dout;
        logic [REQ_BITS-1:0]     hold_src;
        hold_prev = 1'b0;
        hold_dout = '0;
        hold_src  = '0;
        wait (started);
        forever begin
            @(negedge clk);
            #2;
            if (hold_prev) begin
                check("hold_vld_out", 64'(o_vld_out), 64'(1));
                check("hold_dout", 64'(o_dout), 64'(hold_dout));
                check("hold_src_out", 64'(o_src_out), 64'(hold_src));
            end
            if (o_vld_out && i_ack_in) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got dout %0h src %0d with nothing expected",
                             o_dout, o_src_out);
                end else begin
                    e = exp_q.pop_front();
                    check("dout", 64'(o_dout), 64'(e.data));
                    check("src_out", 64'(o_src_out), 64'(e.src));
                end
            end
            hold_prev = o_vld_out && !i_ack_in && !i_reset;
            hold_dout = o_dout;
            hold_src  = o_src_out;
        end
    end

endmodule

// File: doc/leaf_out_rr_arbiter.md
Name: leaf_out_rr_arbiter

Overview:
- Shares one leaf_interface user-to-interface output port between NUM_REQ HLS operator output streams, using round-robin arbitration with a bounded burst per grant.
- Sits inside a leaf wrapper, between operator output streams (TDATA/TVALID/TREADY) and one din_leaf_user2interface/vld/ack port triple.
- Registers the winning stream's data in a one-entry output stage, and tags each word with its source index so software and debug can attribute traffic.

Parameters:
- NUM_REQ, 2, number of requesting streams (≥2).
- PAYLOAD_BITS, 32, data width per stream.
- MAX_BURST, 16, maximum words transferred per grant (≥1).
- REQ_BITS, $clog2(NUM_REQ), width of source index.
- BURST_BITS, $clog2(MAX_BURST)+1, burst counter width.

Ports:
- clk, input, 1, single clock; all logic rising-edge.
- reset, input, 1, synchronous active-high reset.
- enable, input, 1, permits new grants when high.
- din_req, input, NUM_REQ*PAYLOAD_BITS, concatenated requester data; requester i occupies bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
- vld_req, input, NUM_REQ, per-requester valid.
- ack_req, output, NUM_REQ, per-requester ready; combinational.
- dout, output, PAYLOAD_BITS, registered data to the interface.
- vld_out, output, 1, registered valid to the interface.
- ack_in, input, 1, interface ready.
- src_out, output, REQ_BITS, source index of the word on dout.
- busy, output, 1, high while in GRANT state or while vld_out is high.

Behaviour:
- Reset, while reset is high at a clock edge:
  - state=IDLE, rr_ptr=0, grant_idx=0, burst_cnt=0.
  - vld_out=0, dout=0, src_out=0.
  - ack_req=0 during the reset cycle and the cycle after.
  - Reset mid-burst discards any held word (vld_out drops).
- Output stage:
  - Word is "taken" when vld_out && ack_in.
  - Stage is "free" when !vld_out || ack_in.
  - When free and no transfer is accepted, vld_out clears on the next edge.
  - While vld_out && !ack_in, dout/src_out/vld_out hold stable.
- Transfer: xfer = (state==GRANT) && vld_req[grant_idx] && free.
  - ack_req[grant_idx] = (state==GRANT) && free; every other ack_req bit is 0.
  - On xfer, next edge loads dout=din_req[grant_idx], src_out=grant_idx, vld_out=1.
  - Latency: accepted input appears on dout one cycle later.
  - Sustained throughput is 1 word/cycle within a grant.
- IDLE state:
  - If enable && |vld_req, pick the first i with vld_req[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Next edge: grant_idx=i, burst_cnt=0, state=GRANT.
  - Otherwise remain in IDLE.
  - No transfers occur in IDLE, so each re-arbitration costs one bubble cycle.
- GRANT state release, evaluated each cycle:
  - (a) xfer && burst_cnt==MAX_BURST-1 → burst limit reached.
  - (b) !vld_req[grant_idx] → requester dry; no transfer that cycle.
  - (c) !enable, after that cycle's xfer if any.
  - On release: state=IDLE, rr_ptr=(grant_idx+1) mod NUM_REQ, with explicit wrap (NUM_REQ need not be a power of 2).
  - Otherwise, on xfer, burst_cnt increments.
- Backpressure: !free in GRANT does not release the grant; burst_cnt does not advance.
- Simultaneous events:
  - Burst limit and dry requester in the same cycle: only (a) can coincide with xfer; release either way, same rr_ptr update.
  - enable falling mid-burst: the current cycle's xfer completes; no further words from that grant.
- MAX_BURST=1 degenerates to a strict per-word round robin, with one IDLE bubble between words.

Decomposition:
- Shared package leaf_arb_pkg holds:
  - state enum {IDLE, GRANT};
  - a function for the rotated-priority pick;
  - the BURST_BITS/REQ_BITS derivation helpers.
- One natural sub-module: rr_pick (combinational). It takes vld_req and rr_ptr and returns found and idx. It is reusable for the input-side demux controller.

Test Plan:
- Single requester, 20 words continuous, ack_in=1 → words 0..15 appear on consecutive cycles after 1-cycle latency. One bubble follows, then words 16..19. src_out=0 throughout.
- NUM_REQ=2, both valid continuously, MAX_BURST=4 → dout sequence is 4 words from req0, bubble, 4 from req1, bubble, 4 from req0. ack_req is never high for both.
- Backpressure: ack_in low for 5 cycles mid-burst → dout/src_out/vld_out are stable, ack_req[grant]=0, burst_cnt is frozen. Resuming yields no loss or duplication (compare against a scoreboard).
- Reset asserted on the 3rd word of a burst → next cycle vld_out=0 and ack_req=0. After release, arbitration restarts at req0 (rr_ptr=0).
- enable dropped after 2 words of req1's grant (NUM_REQ=3, all valid) → exactly 2 words are transferred and the state returns to IDLE. No grants occur while enable=0. When enable rises, the grant goes to req2 (rr_ptr wrap check: the grant after req2 goes to req0).
- Requester dry mid-burst: req0 drops valid after 3 words while req1 is valid → release after 3 words, one bubble, then req1 is granted. Later, req0 is granted again with burst_cnt reset.
